// File: rtl/vasim_chain_automaton.sv
// rtl/vasim_chain_automaton.sv - chained STE automaton with range matching and a single-entry report buffer
//
// Purpose: a linear chain of NUM_STES state-transition elements. Each STE matches the
//   current symbol against up to RANGES_PER_STE inclusive [lo,hi] slots. STE i is enabled
//   by the previous STE (or by the start mode for STE0) and optionally by its own self-loop.
//   When the last STE becomes active, the offset of the symbol that caused it is reported.
// Optional feature: define VASIM_REPORT_COUNT_EN to add the saturating report_count output.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   run, symbols        symbol valid and symbol value
//   cfg_we, cfg_ste, cfg_range, cfg_lo, cfg_hi, cfg_en   range-table write port
//   start_type          STE0 start mode (0 none, 1 start-of-data, 2 all-input)
//   self_loop           per-STE self-edge enable
//   active              registered STE active vector
//   report_valid/ready  report handshake; report_offset carries the symbol offset
//   report_overflow     sticky lost-report flag
//   report_count        accepted-report count (VASIM_REPORT_COUNT_EN only)
module vasim_chain_automaton #(
  parameter int SYMBOL_WIDTH   = 8,
  parameter int NUM_STES       = 6,
  parameter int RANGES_PER_STE = 4,
  parameter int OFFSET_WIDTH   = 32,
  localparam int STE_IDX_W     = (NUM_STES > 1) ? $clog2(NUM_STES) : 1,
  localparam int RNG_IDX_W     = (RANGES_PER_STE > 1) ? $clog2(RANGES_PER_STE) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic [SYMBOL_WIDTH-1:0] symbols,
  input  logic                    cfg_we,
  input  logic [STE_IDX_W-1:0]    cfg_ste,
  input  logic [RNG_IDX_W-1:0]    cfg_range,
  input  logic [SYMBOL_WIDTH-1:0] cfg_lo,
  input  logic [SYMBOL_WIDTH-1:0] cfg_hi,
  input  logic                    cfg_en,
  input  logic [1:0]              start_type,
  input  logic [NUM_STES-1:0]     self_loop,
  output logic [NUM_STES-1:0]     active,
  output logic                    report_valid,
  input  logic                    report_ready,
  output logic [OFFSET_WIDTH-1:0] report_offset,
`ifdef VASIM_REPORT_COUNT_EN
  output logic [OFFSET_WIDTH-1:0] report_count,
`endif
  output logic                    report_overflow
);

  logic [SYMBOL_WIDTH-1:0]   lo_q     [NUM_STES][RANGES_PER_STE];
  logic [SYMBOL_WIDTH-1:0]   hi_q     [NUM_STES][RANGES_PER_STE];
  logic [RANGES_PER_STE-1:0] slot_en_q[NUM_STES];

  logic [NUM_STES-1:0]     active_q, active_d;
  logic [NUM_STES-1:0]     match, enable;
  logic [OFFSET_WIDTH-1:0] offset_q, offset_d;
  logic                    sod_q, sod_d;
  logic                    valid_q, valid_d;
  logic [OFFSET_WIDTH-1:0] rep_off_q, rep_off_d;
  logic                    ovf_q, ovf_d;
  logic                    report_event;
  logic                    cfg_hit;

  // Indices beyond the table (possible when a count is not a power of two) are dropped.
  assign cfg_hit = cfg_we
                && (32'(cfg_ste)   < 32'(NUM_STES))
                && (32'(cfg_range) < 32'(RANGES_PER_STE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_STES; s++) begin
        slot_en_q[s] <= '0;
        for (int r = 0; r < RANGES_PER_STE; r++) begin
          lo_q[s][r] <= '0;
          hi_q[s][r] <= '0;
        end
      end
    end else if (cfg_hit) begin
      lo_q[cfg_ste][cfg_range]      <= cfg_lo;
      hi_q[cfg_ste][cfg_range]      <= cfg_hi;
      slot_en_q[cfg_ste][cfg_range] <= cfg_en;
    end
  end

  // A slot with lo>hi can never satisfy both bounds, so it needs no special case.
  always_comb begin
    match = '0;
    for (int s = 0; s < NUM_STES; s++) begin
      for (int r = 0; r < RANGES_PER_STE; r++) begin
        if (slot_en_q[s][r] && (lo_q[s][r] <= symbols) && (symbols <= hi_q[s][r])) begin
          match[s] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    enable = '0;
    case (start_type)
      2'd1:    enable[0] = sod_q;
      2'd2:    enable[0] = 1'b1;
      default: enable[0] = 1'b0;
    endcase
    enable[0] = enable[0] | (self_loop[0] & active_q[0]);
    for (int i = 1; i < NUM_STES; i++) begin
      enable[i] = active_q[i-1] | (self_loop[i] & active_q[i]);
    end
  end

  assign active_d     = run ? (enable & match) : active_q;
  assign offset_d     = run ? (offset_q + 1'b1) : offset_q;
  // Start-of-data stays armed until the first symbol actually consumed after reset.
  assign sod_d        = run ? 1'b0 : sod_q;
  assign report_event = run & active_d[NUM_STES-1];

  // The reported offset is the counter value before this cycle's increment,
  // i.e. the offset of the symbol that completed the chain.
  always_comb begin
    valid_d   = valid_q;
    rep_off_d = rep_off_q;
    ovf_d     = ovf_q;
    if (report_event) begin
      if (!valid_q || report_ready) begin
        valid_d   = 1'b1;
        rep_off_d = offset_q;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && report_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q  <= '0;
      offset_q  <= '0;
      sod_q     <= 1'b1;
      valid_q   <= 1'b0;
      rep_off_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      active_q  <= active_d;
      offset_q  <= offset_d;
      sod_q     <= sod_d;
      valid_q   <= valid_d;
      rep_off_q <= rep_off_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef VASIM_REPORT_COUNT_EN
  logic [OFFSET_WIDTH-1:0] count_q, count_d;

  assign count_d = (valid_q && report_ready && (count_q != '1)) ? (count_q + 1'b1) : count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign report_count = count_q;
`endif

  assign active          = active_q;
  assign report_valid    = valid_q;
  assign report_offset   = rep_off_q;
  assign report_overflow = ovf_q;

endmodule

// File: tb/tb_vasim_chain_automaton.sv
// tb/tb_vasim_chain_automaton.sv - self-checking bench for vasim_chain_automaton
module tb_vasim_chain_automaton;

  localparam int SW = 8;
  localparam int NS = 6;
  localparam int RP = 4;
`ifdef VASIM_REPORT_COUNT_EN
  localparam int OW = 4;
`else
  localparam int OW = 32;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b0;
  logic [SW-1:0] symbols = '0;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_ste = '0;
  logic [1:0]    cfg_range = '0;
  logic [SW-1:0] cfg_lo = '0;
  logic [SW-1:0] cfg_hi = '0;
  logic          cfg_en = 1'b0;
  logic [1:0]    start_type = 2'd0;
  logic [NS-1:0] self_loop = '0;
  logic [NS-1:0] active;
  logic          report_valid;
  logic          report_ready = 1'b1;
  logic [OW-1:0] report_offset;
  logic          report_overflow;
`ifdef VASIM_REPORT_COUNT_EN
  logic [OW-1:0] report_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] obs_q[$];

  vasim_chain_automaton #(
    .SYMBOL_WIDTH  (SW),
    .NUM_STES      (NS),
    .RANGES_PER_STE(RP),
    .OFFSET_WIDTH  (OW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
    .symbols        (symbols),
    .cfg_we         (cfg_we),
    .cfg_ste        (cfg_ste),
    .cfg_range      (cfg_range),
    .cfg_lo         (cfg_lo),
    .cfg_hi         (cfg_hi),
    .cfg_en         (cfg_en),
    .start_type     (start_type),
    .self_loop      (self_loop),
    .active         (active),
    .report_valid   (report_valid),
    .report_ready   (report_ready),
    .report_offset  (report_offset),
`ifdef VASIM_REPORT_COUNT_EN
    .report_count   (report_count),
`endif
    .report_overflow(report_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    run    = 1'b0;
    cfg_we = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic cfg_write(input int ste, input int rng, input int lo, input int hi, input bit en);
    cfg_ste   = 3'(ste);
    cfg_range = 2'(rng);
    cfg_lo    = 8'(lo);
    cfg_hi    = 8'(hi);
    cfg_en    = en;
    cfg_we    = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  // STE0='&', STE1={'R','r'}, STE2=digits, STE3='=', STE4=not{9..13,32,38}, STE5='''
  task automatic program_default();
    cfg_write(0, 0, 38, 38, 1'b1);
    cfg_write(1, 0, 82, 82, 1'b1);
    cfg_write(1, 1, 114, 114, 1'b1);
    cfg_write(2, 0, 48, 57, 1'b1);
    cfg_write(3, 0, 61, 61, 1'b1);
    cfg_write(4, 0, 0, 8, 1'b1);
    cfg_write(4, 1, 14, 31, 1'b1);
    cfg_write(4, 2, 33, 37, 1'b1);
    cfg_write(4, 3, 39, 255, 1'b1);
    cfg_write(5, 0, 39, 39, 1'b1);
  endtask

  // Drives one symbol per cycle; every cycle that shows report_valid records the offset.
  task automatic run_stream(input string s);
    for (int i = 0; i < s.len(); i++) begin
      symbols = 8'(s[i]);
      run     = 1'b1;
      tick();
      if (report_valid) obs_q.push_back(report_offset);
    end
    run = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (active !== '0) begin
      n_fail++; $display("FAIL reset_active: got %0h expected 0", active);
    end
    n_tests++;
    if (report_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %0b expected 0", report_valid);
    end
    n_tests++;
    if (report_offset !== '0) begin
      n_fail++; $display("FAIL reset_offset: got %0h expected 0", report_offset);
    end
    n_tests++;
    if (report_overflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_overflow: got %0b expected 0", report_overflow);
    end
`ifdef VASIM_REPORT_COUNT_EN
    n_tests++;
    if (report_count !== '0) begin
      n_fail++; $display("FAIL reset_count: got %0h expected 0", report_count);
    end
`endif
  endtask

  task automatic test_main_stream();
    do_reset();
    program_default();
    start_type   = 2'd2;
    self_loop    = 6'b010000;
    report_ready = 1'b1;
    exp_q.push_back(OW'(6));
    run_stream("&R5=ab'");
    n_tests++;
    if (active !== 6'b110000) begin
      n_fail++; $display("FAIL main_active: got %0h expected 30", active);
    end
    n_tests++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL main_count: got %0d reports expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [OW-1:0] o, e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++; $display("FAIL main_offset: got %0d expected %0d", o, e);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_start_of_data();
    do_reset();
    program_default();
    start_type = 2'd1;
    self_loop  = 6'b010000;
    run_stream("x&R5=a'");
    n_tests++;
    if (obs_q.size() !== 0) begin
      n_fail++; $display("FAIL sod_late_start: got %0d reports expected 0", obs_q.size());
    end
    obs_q.delete();
    do_reset();
    program_default();
    exp_q.push_back(OW'(5));
    run_stream("&R5=a'");
    n_tests++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL sod_count: got %0d reports expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [OW-1:0] o, e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++; $display("FAIL sod_offset: got %0d expected %0d", o, e);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    do_reset();
    program_default();
    start_type   = 2'd2;
    self_loop    = 6'b010000;
    report_ready = 1'b0;
    run_stream("&R5=ab'");
    n_tests++;
    if (report_valid !== 1'b1 || report_offset !== OW'(6) || report_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_first: got valid=%0b off=%0d ovf=%0b expected 1/6/0", report_valid, report_offset, report_overflow);
    end
    run_stream("&R5=ab'");
    n_tests++;
    if (report_valid !== 1'b1 || report_offset !== OW'(6) || report_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_second: got valid=%0b off=%0d ovf=%0b expected 1/6/1", report_valid, report_offset, report_overflow);
    end
    obs_q.delete();
    report_ready = 1'b1;
    tick();
    n_tests++;
    if (report_valid !== 1'b0 || report_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_drain: got valid=%0b ovf=%0b expected 0/1", report_valid, report_overflow);
    end
  endtask

  task automatic test_run_hold();
    do_reset();
    program_default();
    start_type   = 2'd2;
    self_loop    = 6'b010000;
    report_ready = 1'b1;
    run_stream("&R5=");
    for (int i = 0; i < 5; i++) begin
      symbols = 8'($urandom_range(0, 255));
      run     = 1'b0;
      tick();
      n_tests++;
      if (active !== 6'b001000) begin
        n_fail++; $display("FAIL hold_active: cycle %0d got %0h expected 08", i, active);
      end
    end
    exp_q.push_back(OW'(6));
    run_stream("ab'");
    n_tests++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL hold_count: got %0d reports expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [OW-1:0] o, e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++; $display("FAIL hold_offset: got %0d expected %0d", o, e);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_range_edges();
    do_reset();
    program_default();
    start_type   = 2'd2;
    self_loop    = 6'b010000;
    report_ready = 1'b1;
    cfg_write(5, 0, 50, 20, 1'b1);
    run_stream("&R5=ab'");
    n_tests++;
    if (obs_q.size() !== 0) begin
      n_fail++; $display("FAIL range_inverted: got %0d reports expected 0", obs_q.size());
    end
    obs_q.delete();
    cfg_write(5, 0, 39, 39, 1'b0);
    run_stream("&R5=ab'");
    n_tests++;
    if (obs_q.size() !== 0) begin
      n_fail++; $display("FAIL range_disabled: got %0d reports expected 0", obs_q.size());
    end
    obs_q.delete();
    cfg_write(5, 0, 39, 39, 1'b1);
    exp_q.push_back(OW'(20));
    run_stream("&r9=ab'");
    n_tests++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL range_count: got %0d reports expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [OW-1:0] o, e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++; $display("FAIL range_offset: got %0d expected %0d", o, e);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_async_reset();
    do_reset();
    program_default();
    start_type   = 2'd2;
    self_loop    = 6'b010000;
    report_ready = 1'b0;
    run_stream("&R5=ab'");
    run_stream("&R5=ab'");
    run_stream("&R5");
    obs_q.delete();
    n_tests++;
    if (active !== 6'b000100) begin
      n_fail++; $display("FAIL arst_pre_active: got %0h expected 04", active);
    end
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (active !== '0 || report_valid !== 1'b0 || report_offset !== '0 || report_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_clear: got act=%0h valid=%0b off=%0d ovf=%0b expected all 0",
               active, report_valid, report_offset, report_overflow);
    end
    tick();
    reset = 1'b0;
    program_default();
    report_ready = 1'b1;
    exp_q.push_back(OW'(6));
    run_stream("&R5=ab'");
    n_tests++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL arst_count: got %0d reports expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [OW-1:0] o, e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++; $display("FAIL arst_offset: got %0d expected %0d", o, e);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

`ifdef VASIM_REPORT_COUNT_EN
  task automatic test_report_count();
    do_reset();
    program_default();
    start_type   = 2'd2;
    self_loop    = 6'b010000;
    report_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      run_stream("&R5=ab'");
      tick();
      if (i == 10) begin
        n_tests++;
        if (report_count !== 4'd10) begin
          n_fail++; $display("FAIL count_mid: got %0d expected 10", report_count);
        end
      end
    end
    obs_q.delete();
    n_tests++;
    if (report_count !== 4'd15) begin
      n_fail++; $display("FAIL count_sat: got %0d expected 15", report_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_main_stream();
    test_start_of_data();
    test_backpressure();
    test_run_hold();
    test_range_edges();
    test_async_reset();
`ifdef VASIM_REPORT_COUNT_EN
    test_report_count();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
